microwave_cook_ctrl: RTL and testbench
======================================

Name: microwave_cook_ctrl

Overview:
- Cook-cycle sequencer for the microwave. Holds keypad-entered cook time as 4 BCD digits (MM:SS) and counts it down on a prescaled tick.
- Drives mag_on to the magnetron path and pulses timer_done when time expires.
- Sits between the keypad/buttons/door switch and the magnetron S/R logic; timer_done from this block feeds that logic.

Parameters:
- TICK_DIV, 100, clock cycles per 1-second countdown tick (small values for simulation).
- BEEP_CYCLES, 50, length of the end-of-cook beep in clock cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startN  in  1  start button, active-low
- stopN  in  1  stop button, active-low
- clearN  in  1  clear button, active-low
- door_closed  in  1  1 = door closed
- key_valid  in  1  one-cycle strobe qualifying key_digit
- key_digit  in  4  keypad digit (BCD)
- mag_on  out  1  magnetron enable
- timer_done  out  1  one-cycle pulse at countdown expiry
- state  out  2  encoding: 0 = IDLE, 1 = COOK, 2 = PAUSE, 3 = DONE
- min_tens  out  4  BCD digit
- min_ones  out  4  BCD digit
- sec_tens  out  4  BCD digit
- sec_ones  out  4  BCD digit
- beep  out  1  end-of-cook beeper

Behaviour:
Reset:
- resetN low clears all outputs to 0, state to IDLE, digits to 0000, prescaler to 0, and the startN history register to 1.
- Reset takes effect immediately, including mid-COOK; mag_on drops asynchronously.

Inputs:
- start_evt is one cycle on a falling edge of registered startN.
- stopN and clearN are level-sensitive.

Priority each cycle:
- clear, then stop, then door open, then start_evt.

Digit entry:
- Accepted only in IDLE, when key_valid = 1 and key_digit <= 9.
- Shift left: min_tens <= min_ones, min_ones <= sec_tens, sec_tens <= sec_ones, sec_ones <= key_digit.
- Digits > 9 are ignored.
- key_valid is ignored in COOK, PAUSE and DONE.

IDLE:
- clearN = 0: digits <= 0000.
- start_evt with door_closed = 1 and digits != 0000: go to COOK; prescaler <= 0.
- start_evt with digits == 0000: no action.

COOK:
- mag_on = 1.
- The prescaler counts 0..TICK_DIV-1. On wrap, decrement the digits:
  - sec_ones > 0: decrement sec_ones.
  - else sec_tens > 0: sec_tens - 1, sec_ones = 9.
  - else min_ones > 0: min_ones - 1, sec = 59.
  - else min_tens - 1, min_ones = 9, sec = 59.
- Entered seconds of 60..99 count down literally (0:90 lasts 90 ticks).
- A decrement that yields 0000: go to DONE; mag_on falls the same edge.
- clearN = 0 or stopN = 0: go to PAUSE (stop) or IDLE with digits cleared (clear). Clear wins if both are asserted.
- door_closed = 0: go to PAUSE. Prescaler is held, not reset.

PAUSE:
- mag_on = 0; digits and prescaler frozen.
- start_evt with door_closed = 1: resume COOK from the held prescaler value.
- stopN = 0 or clearN = 0: go to IDLE, digits <= 0000.

DONE:
- One cycle only: timer_done = 1, mag_on = 0.
- Next state is IDLE; digits remain 0000.

Simultaneous events:
- start_evt with door open or stop asserted: ignored.
- Expiry tick in the same cycle as stop or door open: stop/door wins; state goes to PAUSE with digits 0000.
- start_evt from PAUSE with digits 0000: go directly to DONE.

Latency:
- mag_on is registered; it rises one cycle after start_evt is detected.

Optional Feature:
- Macro: MICROWAVE_BEEP_EN.
- Defined: a counter loads BEEP_CYCLES on entry to DONE. beep = 1 while the counter is nonzero; the counter decrements each cycle in any state. clearN = 0 or start_evt cancels the beep. Reset clears it.
- Undefined: beep is tied to 0 and no counter is built.

Test Plan:
- TICK_DIV=4. Keys 0,0,0,3; press start with door closed -> mag_on = 1 for 12 cycles; digits go 0003 -> 0002 -> 0001 -> 0000; one-cycle timer_done; state returns to 0.
- Keys 0,1,0,0; start; run 1 tick -> digits 0059 (min_ones = 0, sec_tens = 5, sec_ones = 9).
- In COOK at 0005, set door_closed = 0 mid-tick -> mag_on = 0 next cycle, state = 2, digits frozen; close door and start -> remaining prescaler count honoured, expiry after the correct total cycles.
- In COOK, pulse stopN -> state PAUSE; pulse stopN again -> IDLE with digits 0000. Separately, clearN in COOK -> IDLE and 0000 directly.
- Keys 1,2,0xA,3 in IDLE -> digits 0123. Keys during COOK -> unchanged. Start with 0000 -> stays IDLE, mag_on = 0.
- Assert resetN = 0 mid-COOK -> mag_on = 0 immediately, all outputs 0. With MICROWAVE_BEEP_EN and BEEP_CYCLES = 5 -> beep is high for exactly 5 cycles after DONE.

Source files
------------

// File: rtl/microwave_cook_ctrl_if.sv
// Keypad, button and door inputs plus magnetron, display and beeper outputs of the cook sequencer.
// The bench or panel logic uses the master side; microwave_cook_ctrl uses the slave side.
interface microwave_cook_ctrl_if;
  logic       startN;
  logic       stopN;
  logic       clearN;
  logic       door_closed;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       mag_on;
  logic       timer_done;
  logic [1:0] state;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       beep;

  modport master (
    output startN, stopN, clearN, door_closed, key_valid, key_digit,
    input  mag_on, timer_done, state, min_tens, min_ones, sec_tens, sec_ones, beep
  );

  modport slave (
    input  startN, stopN, clearN, door_closed, key_valid, key_digit,
    output mag_on, timer_done, state, min_tens, min_ones, sec_tens, sec_ones, beep
  );
endinterface

// File: rtl/microwave_cook_ctrl.sv
// Cook-time sequencer: BCD MM:SS entry, prescaled countdown, magnetron enable and expiry pulse; MICROWAVE_BEEP_EN adds the end-of-cook beeper.
// Latency: mag_on rises one cycle after the start edge is detected; no backpressure, key strobes outside IDLE are dropped.
module microwave_cook_ctrl #(
  parameter int TICK_DIV    = 100,
  parameter int BEEP_CYCLES = 50
) (
  input  logic                 clk,
  input  logic                 resetN,
  microwave_cook_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } cookState;

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  cookState         curState;
  logic [PRE_W-1:0] preCnt;
  logic [3:0]       minT, minO, secT, secO;
  logic [3:0]       decMinT, decMinO, decSecT, decSecO;
  logic             magOn, doneP;
  logic             startSync, startPrev;
  logic             startEvt, digitsNz, decZero, tickWrap, keyOk, goDone;

  // startN is registered twice so the edge detector never sees the raw pin.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      startSync <= 1'b1;
      startPrev <= 1'b1;
    end else begin
      startSync <= bus.startN;
      startPrev <= startSync;
    end
  end

  assign startEvt = startPrev & ~startSync;
  assign digitsNz = |{minT, minO, secT, secO};
  assign tickWrap = (curState == COOK) && (preCnt == PRE_LAST);
  assign keyOk    = (curState == IDLE) && bus.key_valid && (bus.key_digit <= 4'd9);

  always_comb begin
    decMinT = minT;
    decMinO = minO;
    decSecT = secT;
    decSecO = secO;
    if (secO != 4'd0) begin
      decSecO = secO - 4'd1;
    end else if (secT != 4'd0) begin
      decSecT = secT - 4'd1;
      decSecO = 4'd9;
    end else if (minO != 4'd0) begin
      decMinO = minO - 4'd1;
      decSecT = 4'd5;
      decSecO = 4'd9;
    end else if (minT != 4'd0) begin
      decMinT = minT - 4'd1;
      decMinO = 4'd9;
      decSecT = 4'd5;
      decSecO = 4'd9;
    end
  end

  assign decZero = ~|{decMinT, decMinO, decSecT, decSecO};

  // Expiry from COOK, or a resume request from PAUSE with nothing left on the clock.
  assign goDone = ((curState == COOK) && bus.clearN && bus.stopN && bus.door_closed &&
                   tickWrap && decZero) ||
                  ((curState == PAUSE) && bus.clearN && bus.stopN && bus.door_closed &&
                   startEvt && !digitsNz);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      curState <= IDLE;
      preCnt   <= '0;
      minT     <= 4'd0;
      minO     <= 4'd0;
      secT     <= 4'd0;
      secO     <= 4'd0;
      magOn    <= 1'b0;
      doneP    <= 1'b0;
    end else begin
      doneP <= 1'b0;
      case (curState)
        IDLE: begin
          if (!bus.clearN) begin
            {minT, minO, secT, secO} <= 16'd0;
          end else if (startEvt && bus.stopN && bus.door_closed && digitsNz) begin
            curState <= COOK;
            preCnt   <= '0;
            magOn    <= 1'b1;
          end else if (keyOk) begin
            minT <= minO;
            minO <= secT;
            secT <= secO;
            secO <= bus.key_digit;
          end
        end

        COOK: begin
          // The cycle that sees stop/door still counts; only PAUSE freezes the prescaler.
          if (tickWrap) begin
            preCnt <= '0;
            if (digitsNz) begin
              {minT, minO, secT, secO} <= {decMinT, decMinO, decSecT, decSecO};
            end
          end else begin
            preCnt <= preCnt + PRE_W'(1);
          end

          if (!bus.clearN) begin
            curState                 <= IDLE;
            magOn                    <= 1'b0;
            {minT, minO, secT, secO} <= 16'd0;
          end else if (!bus.stopN || !bus.door_closed) begin
            curState <= PAUSE;
            magOn    <= 1'b0;
          end else if (goDone) begin
            curState <= DONE;
            magOn    <= 1'b0;
            doneP    <= 1'b1;
          end
        end

        PAUSE: begin
          if (!bus.clearN || !bus.stopN) begin
            curState                 <= IDLE;
            {minT, minO, secT, secO} <= 16'd0;
          end else if (goDone) begin
            curState <= DONE;
            doneP    <= 1'b1;
          end else if (startEvt && bus.door_closed) begin
            curState <= COOK;
            magOn    <= 1'b1;
          end
        end

        DONE: begin
          curState <= IDLE;
        end

        default: begin
          curState <= IDLE;
          magOn    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mag_on     = magOn;
  assign bus.timer_done = doneP;
  assign bus.state      = curState;
  assign bus.min_tens   = minT;
  assign bus.min_ones   = minO;
  assign bus.sec_tens   = secT;
  assign bus.sec_ones   = secO;

`ifdef MICROWAVE_BEEP_EN
  localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);

  logic [BEEP_W-1:0] beepCnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      beepCnt <= '0;
    end else if (goDone) begin
      beepCnt <= BEEP_W'(BEEP_CYCLES);
    end else if (!bus.clearN || startEvt) begin
      beepCnt <= '0;
    end else if (beepCnt != '0) begin
      beepCnt <= beepCnt - BEEP_W'(1);
    end
  end

  assign bus.beep = (beepCnt != '0);
`else
  // No beeper built; the comparison only keeps BEEP_CYCLES referenced and is constant 0.
  assign bus.beep = (BEEP_CYCLES < 0);
`endif

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
module tb_microwave_cook_ctrl;
  localparam int TICK_DIV    = 4;
  localparam int BEEP_CYCLES = 5;

  logic clk    = 1'b0;
  logic resetN = 1'b1;

  microwave_cook_ctrl_if bus();

  microwave_cook_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .BEEP_CYCLES(BEEP_CYCLES)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int expMag[$];
  int magCnt = 0;

  task automatic checkVal(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int digits();
    return {16'd0, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction

  // Scoreboard consumer: each timer_done pops the expected magnetron-on cycle count.
  always @(negedge clk) begin
    if (!resetN) begin
      magCnt = 0;
    end else begin
      if (bus.mag_on) magCnt++;
      if (bus.timer_done) begin
        checkVal("doneState", int'(bus.state), 3);
        if (expMag.size() == 0) checkVal("doneQueued", expMag.size(), 1);
        else checkVal("magCycles", magCnt, expMag.pop_front());
        magCnt = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pressKey(input logic [3:0] d);
    bus.key_digit = d;
    bus.key_valid = 1'b1;
    tick(1);
    bus.key_valid = 1'b0;
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    pressKey(a);
    pressKey(b);
    pressKey(c);
    pressKey(d);
  endtask

  task automatic pressStart();
    bus.startN = 1'b0;
    tick(1);
    bus.startN = 1'b1;
  endtask

  task automatic waitState(input int target, input int budget, input string tag);
    int seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      @(negedge clk);
      if (int'(bus.state) == target) seen = 1;
    end
    checkVal(tag, seen, 1);
  endtask

  task automatic checkBeepAtDone(input string tag);
    int cnt;
`ifdef MICROWAVE_BEEP_EN
    cnt = int'(bus.beep);
    repeat (9) begin
      @(negedge clk);
      cnt += int'(bus.beep);
    end
    checkVal(tag, cnt, BEEP_CYCLES);
`else
    cnt = int'(bus.beep);
    checkVal(tag, cnt, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.startN      = 1'b1;
    bus.stopN       = 1'b1;
    bus.clearN      = 1'b1;
    bus.door_closed = 1'b1;
    bus.key_valid   = 1'b0;
    bus.key_digit   = 4'd0;

    #3 resetN = 1'b0;
    #1;
    checkVal("rstMag",    int'(bus.mag_on), 0);
    checkVal("rstState",  int'(bus.state), 0);
    checkVal("rstDigits", digits(), 'h0000);
    checkVal("rstDone",   int'(bus.timer_done), 0);
    checkVal("rstBeep",   int'(bus.beep), 0);
    tick(2);
    resetN = 1'b1;
    tick(1);

    // Entry with an invalid digit in the middle, then clear in IDLE.
    enter4(4'd1, 4'd2, 4'hA, 4'd3);
    checkVal("keyEntry", digits(), 'h0123);
    bus.clearN = 1'b0;
    tick(1);
    bus.clearN = 1'b1;
    checkVal("idleClear", digits(), 'h0000);

    pressStart();
    tick(3);
    checkVal("zeroStartState", int'(bus.state), 0);
    checkVal("zeroStartMag",   int'(bus.mag_on), 0);

    // 0:03 runs 12 cycles.
    enter4(4'd0, 4'd0, 4'd0, 4'd3);
    magCnt = 0;
    expMag.push_back(3 * TICK_DIV);
    pressStart();
    tick(1);
    checkVal("cookState", int'(bus.state), 1);
    checkVal("cookMag",   int'(bus.mag_on), 1);
    checkVal("cookD3",    digits(), 'h0003);
    tick(TICK_DIV);
    checkVal("cookD2",    digits(), 'h0002);
    tick(TICK_DIV);
    checkVal("cookD1",    digits(), 'h0001);
    waitState(3, 10, "reachDone1");
    checkVal("doneDigits", digits(), 'h0000);
    checkVal("doneMag",    int'(bus.mag_on), 0);
    checkBeepAtDone("beepCycles");
    tick(1);
    checkVal("afterDoneState", int'(bus.state), 0);
    checkVal("afterDoneTd",    int'(bus.timer_done), 0);

    // Minute borrow, keys ignored while cooking, clear in COOK.
    enter4(4'd0, 4'd1, 4'd0, 4'd0);
    pressStart();
    tick(1);
    tick(TICK_DIV);
    checkVal("borrow59", digits(), 'h0059);
    pressKey(4'd5);
    checkVal("keyInCook", digits(), 'h0059);
    bus.clearN = 1'b0;
    tick(1);
    bus.clearN = 1'b1;
    checkVal("cookClearState",  int'(bus.state), 0);
    checkVal("cookClearDigits", digits(), 'h0000);
    checkVal("cookClearMag",    int'(bus.mag_on), 0);

    // Door opened mid-tick, resume keeps the prescaler: 0:05 totals 20 on-cycles.
    enter4(4'd0, 4'd0, 4'd0, 4'd5);
    magCnt = 0;
    expMag.push_back(5 * TICK_DIV);
    pressStart();
    tick(1);
    tick(TICK_DIV + 2);
    bus.door_closed = 1'b0;
    tick(1);
    checkVal("doorPauseState", int'(bus.state), 2);
    checkVal("doorPauseMag",   int'(bus.mag_on), 0);
    checkVal("doorPauseDig",   digits(), 'h0004);
    tick(3);
    checkVal("doorFrozenDig",  digits(), 'h0004);
    pressStart();
    tick(1);
    checkVal("openStartIgnored", int'(bus.state), 2);
    bus.door_closed = 1'b1;
    pressStart();
    tick(1);
    checkVal("resumeState", int'(bus.state), 1);
    waitState(3, 40, "reachDone2");
    tick(1);

    // Stop pauses, second stop returns to IDLE with digits cleared.
    enter4(4'd0, 4'd0, 4'd1, 4'd0);
    pressStart();
    tick(1);
    tick(2);
    bus.stopN = 1'b0;
    tick(1);
    bus.stopN = 1'b1;
    checkVal("stopPauseState", int'(bus.state), 2);
    checkVal("stopPauseMag",   int'(bus.mag_on), 0);
    checkVal("stopPauseDig",   digits(), 'h0010);
    bus.stopN = 1'b0;
    tick(1);
    bus.stopN = 1'b1;
    checkVal("stopIdleState", int'(bus.state), 0);
    checkVal("stopIdleDig",   digits(), 'h0000);

    // Stop on the expiry tick: PAUSE at 0000, then start goes straight to DONE.
    enter4(4'd0, 4'd0, 4'd0, 4'd1);
    magCnt = 0;
    expMag.push_back(TICK_DIV);
    pressStart();
    tick(1);
    tick(TICK_DIV - 1);
    bus.stopN = 1'b0;
    tick(1);
    bus.stopN = 1'b1;
    checkVal("expStopState", int'(bus.state), 2);
    checkVal("expStopDig",   digits(), 'h0000);
    pressStart();
    waitState(3, 6, "pauseZeroDone");
    tick(1);
    checkVal("pauseZeroIdle", int'(bus.state), 0);

    // Asynchronous reset mid-COOK.
    enter4(4'd0, 4'd0, 4'd0, 4'd9);
    pressStart();
    tick(4);
    checkVal("preRstMag", int'(bus.mag_on), 1);
    #2 resetN = 1'b0;
    #1;
    checkVal("asyncRstMag",    int'(bus.mag_on), 0);
    checkVal("asyncRstState",  int'(bus.state), 0);
    checkVal("asyncRstDigits", digits(), 'h0000);
    checkVal("asyncRstBeep",   int'(bus.beep), 0);
    tick(2);
    resetN = 1'b1;
    tick(2);

    checkVal("sbEmpty", expMag.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
